// File: rtl/pipelined_memory_arbiter.sv
// pipelined_memory_arbiter: round-robin multi-port access to an inferred RAM with a fixed-latency response pipeline
module pipelined_memory_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PORTS  = 2,
  parameter int LATENCY    = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic                             rsp_write,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [$clog2(LATENCY+1)-1:0]     outstanding,
  output logic                             busy
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int OW = $clog2(LATENCY+1);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [PW-1:0]         ptr, gidx, j;
  logic                  acc;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [OW-1:0]         cnt;
  logic                  st_v [LATENCY];
  logic [PW-1:0]         st_p [LATENCY];
  logic                  st_w [LATENCY];
  logic [DATA_WIDTH-1:0] st_d [LATENCY];
  // grant the first valid port at or above the pointer, wrapping around
  always_comb begin
    req_ready = '0;
    gidx = '0;
    j = '0;
    acc = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = PW'((int'(ptr) + k) % NUM_PORTS);
      if (!acc && req_valid[j]) begin
        acc = 1'b1;
        gidx = j;
        req_ready[j] = 1'b1;
      end
    end
  end
  assign sel_write = req_write[gidx];
  assign sel_addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = req_data[gidx*DATA_WIDTH +: DATA_WIDTH];
  // RAM write port; contents survive reset
  always_ff @(posedge clk_in) begin
    if (acc && sel_write) mem[sel_addr] <= sel_data;
  end
  // pointer, outstanding count and response pipeline; payload only moves with a valid so the output holds
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr <= '0;
      cnt <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        st_v[k] <= 1'b0;
        st_p[k] <= '0;
        st_w[k] <= 1'b0;
        st_d[k] <= '0;
      end
    end else begin
      if (acc) ptr <= (gidx == PW'(NUM_PORTS-1)) ? '0 : gidx + 1'b1;
      cnt <= cnt + OW'(acc) - OW'(st_v[LATENCY-1]);
      st_v[0] <= acc;
      if (acc) begin
        st_p[0] <= gidx;
        st_w[0] <= sel_write;
        st_d[0] <= sel_write ? sel_data : mem[sel_addr];
      end
      for (int k = 1; k < LATENCY; k++) begin
        st_v[k] <= st_v[k-1];
        if (st_v[k-1]) begin
          st_p[k] <= st_p[k-1];
          st_w[k] <= st_w[k-1];
          st_d[k] <= st_d[k-1];
        end
      end
    end
  end
  // one-hot response strobe from the last stage
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) rsp_valid[i] = st_v[LATENCY-1] && (st_p[LATENCY-1] == PW'(i));
  end
  assign rsp_write   = st_w[LATENCY-1];
  assign rsp_data    = st_d[LATENCY-1];
  assign outstanding = cnt;
  assign busy        = cnt != '0;
endmodule

// File: tb/tb_pipelined_memory_arbiter.sv
// tb_pipelined_memory_arbiter: directed checks of arbitration, pipelining, counters and reset
module tb_pipelined_memory_arbiter;
  localparam int DW = 64, AW = 10, NP = 2, L = 2;
  localparam int BDW = 16, BAW = 4, BNP = 4;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0;
  always #5 clk_in = ~clk_in;

  logic [NP-1:0]    req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_data = '0;
  logic             rsp_write, busy;
  logic [DW-1:0]    rsp_data;
  logic [1:0]       outstanding;

  logic [BNP-1:0]     b_valid = '0, b_ready, b_write = '0, b_rsp_valid;
  logic [BNP*BAW-1:0] b_addr = '0;
  logic [BNP*BDW-1:0] b_data = '0;
  logic               b_rsp_write, b_busy;
  logic [BDW-1:0]     b_rsp_data;
  logic [0:0]         b_out;

  pipelined_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .LATENCY(L)) u0 (
    .clk_in(clk_in), .rst_n_in(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_write(rsp_write), .rsp_data(rsp_data), .outstanding(outstanding), .busy(busy));

  pipelined_memory_arbiter #(.DATA_WIDTH(BDW), .ADDR_WIDTH(BAW), .NUM_PORTS(BNP), .LATENCY(1)) u1 (
    .clk_in(clk_in), .rst_n_in(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_addr(b_addr), .req_data(b_data), .rsp_valid(b_rsp_valid),
    .rsp_write(b_rsp_write), .rsp_data(b_rsp_data), .outstanding(b_out), .busy(b_busy));

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = v;
    req_write[p] = w;
    req_addr[p*AW +: AW] = a;
    req_data[p*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    tests++; if (rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    tests++; if (outstanding !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL reset_cnt got %0d/%b exp 0/0", outstanding, busy); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL idle_ready got %b exp 00", req_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    set_port(0, 1, 1, 5, 64'hAA);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL wr_ready got %b exp 01", req_ready); end
    tick();
    set_port(0, 1, 0, 5, 0);
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_write !== 1'b1 || rsp_data !== 64'hAA) begin fails++; $display("FAIL wr_rsp got %b/%b/%h exp 01/1/aa", rsp_valid, rsp_write, rsp_data); end
    tests++; if (outstanding !== 2'd2 || busy !== 1'b1) begin fails++; $display("FAIL wr_cnt got %0d/%b exp 2/1", outstanding, busy); end
    set_port(0, 0, 0, 0, 0);
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_write !== 1'b0 || rsp_data !== 64'hAA) begin fails++; $display("FAIL rd_rsp got %b/%b/%h exp 01/0/aa", rsp_valid, rsp_write, rsp_data); end
    tests++; if (outstanding !== 2'd1) begin fails++; $display("FAIL rd_cnt got %0d exp 1", outstanding); end
    tick();
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_data !== 64'hAA) begin fails++; $display("FAIL wr_drain got %b/%b/%h exp 00/0/aa", rsp_valid, busy, rsp_data); end
  endtask

  task automatic test_alternate();
    set_port(1, 1, 1, 1, 64'h11);
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL pre_ready got %b exp 10", req_ready); end
    tick();
    set_port(1, 1, 1, 2, 64'h22);
    tick();
    set_port(1, 0, 0, 0, 0);
    tick();
    tick();
    set_port(0, 1, 0, 1, 0);
    set_port(1, 1, 0, 2, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL alt_ready[%0d] got %b", k, req_ready); end
      tick();
      if (k >= 1) begin
        tests++; if (rsp_valid !== (((k-1) % 2) ? 2'b10 : 2'b01) || rsp_data !== (((k-1) % 2) ? 64'h22 : 64'h11)) begin fails++; $display("FAIL alt_rsp[%0d] got %b/%h", k, rsp_valid, rsp_data); end
        tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL alt_cnt[%0d] got %0d exp 2", k, outstanding); end
      end
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_data !== 64'h11) begin fails++; $display("FAIL alt_last got %b/%h exp 01/11", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_no_bubble();
    set_port(0, 1, 0, 2, 0);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL nb_ready got %b exp 01", req_ready); end
    tick();
    set_port(0, 0, 0, 0, 0);
    tests++; if (outstanding !== 2'd1) begin fails++; $display("FAIL nb_cnt got %0d exp 1", outstanding); end
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_data !== 64'h22) begin fails++; $display("FAIL nb_rsp got %b/%h exp 01/22", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] base;
    base = 64'hC0DE_0000_0000_0000;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) set_port(0, 1, 1, AW'(c), base + DW'(c));
      else if (c < 8) set_port(0, 1, 0, AW'(c-4), 0);
      else set_port(0, 0, 0, 0, 0);
      tick();
      if (c >= 1) begin
        tests++; if (rsp_valid !== 2'b01 || rsp_write !== (c-1 < 4) || rsp_data !== base + DW'((c-1) % 4)) begin fails++; $display("FAIL b2b_rsp[%0d] got %b/%b/%h", c-1, rsp_valid, rsp_write, rsp_data); end
      end
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_hold got %b exp 1", busy); end
    tick();
    tests++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin fails++; $display("FAIL b2b_busy_end got %b/%b exp 0/00", busy, rsp_valid); end
  endtask

  task automatic test_mid_reset();
    set_port(0, 1, 1, 9, 64'h99);
    tick();
    set_port(0, 1, 0, 0, 0);
    tick();
    set_port(0, 1, 0, 1, 0);
    tick();
    set_port(0, 0, 0, 0, 0);
    tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL mr_pre_cnt got %0d exp 2", outstanding); end
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 2'b00 || outstanding !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL mr_async got %b/%0d/%b exp 00/0/0", rsp_valid, outstanding, busy); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL mr_stale[%0d] got %b exp 00", k, rsp_valid); end
    end
    set_port(0, 1, 0, 9, 0);
    tick();
    set_port(0, 0, 0, 0, 0);
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_data !== 64'h99) begin fails++; $display("FAIL mr_keep got %b/%h exp 01/99", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_lat1_four_ports();
    logic [BNP-1:0] ex;
    for (int p = 0; p < 3; p++) begin
      b_valid[p] = 1'b1;
      b_write[p] = 1'b1;
      b_addr[p*BAW +: BAW] = BAW'(p);
      b_data[p*BDW +: BDW] = BDW'(16'h100 + p);
    end
    for (int k = 0; k < 4; k++) begin
      ex = 4'b0001 << (k % 3);
      #1;
      tests++; if (b_ready !== ex) begin fails++; $display("FAIL l1_ready[%0d] got %b exp %b", k, b_ready, ex); end
      tick();
      tests++; if (b_rsp_valid !== ex || b_rsp_write !== 1'b1 || b_rsp_data !== BDW'(16'h100 + k % 3)) begin fails++; $display("FAIL l1_rsp[%0d] got %b/%b/%h exp %b", k, b_rsp_valid, b_rsp_write, b_rsp_data, ex); end
      tests++; if (b_out !== 1'b1 || b_busy !== 1'b1) begin fails++; $display("FAIL l1_cnt[%0d] got %b/%b exp 1/1", k, b_out, b_busy); end
    end
    b_valid = '0;
    tick();
    tests++; if (b_rsp_valid !== 4'b0000 || b_out !== 1'b0 || b_busy !== 1'b0) begin fails++; $display("FAIL l1_drain got %b/%b/%b exp 0000/0/0", b_rsp_valid, b_out, b_busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_no_bubble();
    test_back_to_back();
    test_mid_reset();
    test_lat1_four_ports();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
